// File: rtl/mem_spi_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg : shared constants for the memory-controller SPI responder.
//   - SPI SRAM opcodes (READ / WRITE / WRMR) and the sequential-mode value
//   - frame lengths for read/write transfers and the mode-register write
//   - request FSM state encoding (plain 2-bit constants)
//   - word-to-byte address conversion
// No ports (package).
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [7:0] SPI_READ      = 8'h03;
    localparam logic [7:0] SPI_WRITE     = 8'h02;
    localparam logic [7:0] SPI_WRMR      = 8'h01;
    localparam logic [7:0] SRAM_MODE_SEQ = 8'h40;

    // {opcode, byte address, data16} and {WRMR, mode}
    localparam int FRAME_RW_BITS   = 40;
    localparam int FRAME_INIT_BITS = 16;
    localparam int FRAME_MAX_BITS  = 40;

    // Controller addresses 16-bit words; the SRAM addresses bytes.
    localparam int WORD_TO_BYTE_SHIFT = 1;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // The shift drops word-address bit 15 by construction, so the byte
    // address wraps inside the 64 KiB SRAM.
    function automatic logic [15:0] word_to_byte(input logic [15:0] word_addr);
        return word_addr << WORD_TO_BYTE_SHIFT;
    endfunction

endpackage

// File: rtl/mem_spi_responder_if.sv
// -----------------------------------------------------------------------------
// mem_spi_responder_if : memory-controller <-> responder request bus.
//   mem_req     controller -> responder  request strobe
//   memory_we   controller -> responder  1=write, 0=read
//   address_in  controller -> responder  16-bit word address
//   wdata_in    controller -> responder  16-bit write data
//   data_out    responder  -> controller read data
//   mem_ready   responder  -> controller idle / accepting
// Handshake: a request is accepted on exactly those clk cycles where
// mem_req=1 and mem_ready=1; memory_we/address_in/wdata_in are sampled on
// that cycle only. mem_req while mem_ready=0 is dropped, never queued.
// data_out is valid from the cycle mem_ready returns high after a read and
// holds until the next read completes.
// -----------------------------------------------------------------------------
interface mem_spi_responder_if;
    logic        mem_req;
    logic        memory_we;
    logic [15:0] address_in;
    logic [15:0] wdata_in;
    logic [15:0] data_out;
    logic        mem_ready;

    modport master (
        output mem_req, memory_we, address_in, wdata_in,
        input  data_out, mem_ready
    );

    modport slave (
        input  mem_req, memory_we, address_in, wdata_in,
        output data_out, mem_ready
    );
endinterface

// File: rtl/mem_spi_responder_spi_shift_engine.sv
// -----------------------------------------------------------------------------
// spi_shift_engine : generic mode-0 SPI shifter, up to MAX_BITS per frame.
//   clk, rst  system clock, synchronous active-high reset
//   start_i   load frame_i (left aligned) and begin shifting len_i bits
//   frame_i   frame, MSB first
//   len_i     number of bits to send (2*len_i SCK toggles)
//   busy_o    transfer in progress
//   done_o    high on the cycle of the final (falling) SCK toggle
//   sck_o     SPI clock, idles low
//   mosi_o    serial out; changes on SCK falling edges
//   miso_i    serial in; sampled on SCK rising edges
//   rx_o      last 16 bits received, MSB first
// SCK half-period is CLK_DIV clk cycles (1..255).
// -----------------------------------------------------------------------------
module spi_shift_engine #(
    parameter int CLK_DIV  = 2,
    parameter int MAX_BITS = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [MAX_BITS-1:0] frame_i,
    input  logic [5:0]          len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                sck_o,
    output logic                mosi_o,
    input  logic                miso_i,
    output logic [15:0]         rx_o
);
    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

    logic                busy_q, busy_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic [MAX_BITS-1:0] sh_q, sh_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [6:0]          tog_q, tog_d;
    logic [6:0]          last_q, last_d;
    logic [15:0]         rx_q, rx_d;
    logic                expire;
    logic                last_toggle;

    assign expire      = busy_q && (cnt_q == 8'd0);
    assign last_toggle = expire && (tog_q == last_q);

    always_comb begin
        busy_d = busy_q;
        sck_d  = sck_q;
        mosi_d = mosi_q;
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        tog_d  = tog_q;
        last_d = last_q;
        rx_d   = rx_q;
        if (start_i && !busy_q) begin
            // First bit goes out immediately; SCK stays low for one half-period.
            busy_d = 1'b1;
            sck_d  = 1'b0;
            mosi_d = frame_i[MAX_BITS-1];
            sh_d   = {frame_i[MAX_BITS-2:0], 1'b0};
            cnt_d  = DIV_RELOAD;
            tog_d  = 7'd0;
            last_d = {len_i, 1'b0} - 7'd1;
        end else if (expire) begin
            cnt_d = DIV_RELOAD;
            sck_d = ~sck_q;
            tog_d = tog_q + 7'd1;
            if (!sck_q) begin
                rx_d = {rx_q[14:0], miso_i};
            end else begin
                mosi_d = sh_q[MAX_BITS-1];
                sh_d   = {sh_q[MAX_BITS-2:0], 1'b0};
            end
            if (last_toggle) begin
                busy_d = 1'b0;
                mosi_d = 1'b0;
            end
        end else if (busy_q) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            sck_q  <= 1'b0;
            mosi_q <= 1'b0;
            sh_q   <= '0;
            cnt_q  <= 8'd0;
            tog_q  <= 7'd0;
            last_q <= 7'd0;
            rx_q   <= 16'h0000;
        end else begin
            busy_q <= busy_d;
            sck_q  <= sck_d;
            mosi_q <= mosi_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            tog_q  <= tog_d;
            last_q <= last_d;
            rx_q   <= rx_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = last_toggle;
    assign sck_o  = sck_q;
    assign mosi_o = mosi_q;
    assign rx_o   = rx_q;

endmodule

// File: rtl/mem_spi_responder.sv
// -----------------------------------------------------------------------------
// mem_spi_responder : serves single-word memory-controller requests from a
// 23LC512-class SPI SRAM in sequential mode.
//   clk, rst     system clock, synchronous active-high reset
//   bus          mem_spi_responder_if.slave (mem_req, memory_we, address_in,
//                wdata_in in; data_out, mem_ready out)
//   spi_sck      SPI clock, mode 0
//   spi_cs_n     SRAM chip select, active low
//   spi_mosi     serial data to SRAM
//   spi_miso     serial data from SRAM
//   dbg_state_o  request FSM state (mem_pkg ST_* encoding)
// Optional build macro MEM_SPI_INIT_EN: after reset, write the SRAM mode
// register (sequential mode) before accepting the first request.
// -----------------------------------------------------------------------------
module mem_spi_responder
    import mem_pkg::*;
#(
    parameter int         CLK_DIV   = 2,
    parameter logic [7:0] CMD_READ  = SPI_READ,
    parameter logic [7:0] CMD_WRITE = SPI_WRITE
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_spi_responder_if.slave    bus,
    output logic                  spi_sck,
    output logic                  spi_cs_n,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic [1:0]            dbg_state_o
);
`ifdef MEM_SPI_INIT_EN
    localparam logic [1:0] ST_RESET = ST_INIT;
`else
    localparam logic [1:0] ST_RESET = ST_IDLE;
`endif

    logic [1:0]                state_q, state_d;
    logic                      cs_n_q, cs_n_d;
    logic                      we_q, we_d;
    logic [15:0]               data_q, data_d;
    logic                      eng_start;
    logic [FRAME_MAX_BITS-1:0] eng_frame;
    logic [5:0]                eng_len;
    logic                      eng_busy;
    logic                      eng_done;
    logic [15:0]               eng_rx;
    logic [FRAME_MAX_BITS-1:0] frame_rw;

    // Reads carry a zero data field; the SRAM ignores MOSI during data-out.
    assign frame_rw = {bus.memory_we ? CMD_WRITE : CMD_READ,
                       word_to_byte(bus.address_in),
                       bus.memory_we ? bus.wdata_in : 16'h0000};

    always_comb begin
        state_d   = state_q;
        cs_n_d    = cs_n_q;
        we_d      = we_q;
        data_d    = data_q;
        eng_start = 1'b0;
        eng_frame = frame_rw;
        eng_len   = 6'(FRAME_RW_BITS);
        case (state_q)
`ifdef MEM_SPI_INIT_EN
            ST_INIT: begin
                // Treated as a write so DONE leaves data_out alone.
                eng_start = 1'b1;
                eng_frame = {SPI_WRMR, SRAM_MODE_SEQ, 24'h000000};
                eng_len   = 6'(FRAME_INIT_BITS);
                we_d      = 1'b1;
                cs_n_d    = 1'b0;
                state_d   = ST_SHIFT;
            end
`endif
            ST_IDLE: begin
                if (bus.mem_req) begin
                    eng_start = 1'b1;
                    we_d      = bus.memory_we;
                    cs_n_d    = 1'b0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (eng_done) begin
                    cs_n_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!we_q) begin
                    data_d = eng_rx;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            cs_n_q  <= 1'b1;
            we_q    <= 1'b0;
            data_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            we_q    <= we_d;
            data_q  <= data_d;
        end
    end

    spi_shift_engine #(
        .CLK_DIV  (CLK_DIV),
        .MAX_BITS (FRAME_MAX_BITS)
    ) u_engine (
        .clk     (clk),
        .rst     (rst),
        .start_i (eng_start),
        .frame_i (eng_frame),
        .len_i   (eng_len),
        .busy_o  (eng_busy),
        .done_o  (eng_done),
        .sck_o   (spi_sck),
        .mosi_o  (spi_mosi),
        .miso_i  (spi_miso),
        .rx_o    (eng_rx)
    );

    // The engine is always idle in IDLE; the busy term is an interlock only.
    assign bus.mem_ready = (state_q == ST_IDLE) && !eng_busy;
    assign bus.data_out  = data_q;
    assign spi_cs_n      = cs_n_q;
    assign dbg_state_o   = state_q;

endmodule
